// File: rtl/ram_param_if.sv
// ---------------------------------------------------------------------------
// ram_param_if
// Groups the access bus of ram_param into one bundle.
//
// Signals:
//   clr     master->slave  single-cycle request to re-run the clear sweep
//   req     master->slave  access request, accepted when req && rdy
//   we      master->slave  byte write enables (all-zero = read)
//   addr    master->slave  word address
//   din     master->slave  write data
//   dout    slave->master  registered read data
//   rvalid  slave->master  one-cycle strobe marking dout valid for an access
//   busy    slave->master  clear sweep in progress
//   rdy     slave->master  an access can be accepted this cycle
// ---------------------------------------------------------------------------
interface ram_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();

  logic                  clr;
  logic                  req;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  rvalid;
  logic                  busy;
  logic                  rdy;

  modport master (
    output clr, req, we, addr, din,
    input  dout, rvalid, busy, rdy
  );

  modport slave (
    input  clr, req, we, addr, din,
    output dout, rvalid, busy, rdy
  );

endinterface

// File: rtl/ram_param.sv
// ---------------------------------------------------------------------------
// ram_param
// Parametrised single-port synchronous RAM with per-byte write enables,
// a 1- or 2-cycle registered read pipeline with a valid strobe, selectable
// read-during-write result and a clear sequencer that fills every word with
// CLR_VAL after reset or on request.
//
// Parameters:
//   DATA_W    word width in bits (multiple of 8)
//   ADDR_W    address width, depth = 2**ADDR_W
//   RD_LAT    read latency, 1 or 2
//   RDW_MODE  0: a write returns the old word, 1: the merged new word
//   CLR_VAL   value written to every word by the clear sweep
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      ram_param_if slave modport (clr/req/we/addr/din in,
//            dout/rvalid/busy/rdy out)
// ---------------------------------------------------------------------------
module ram_param #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                RD_LAT   = 1,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_param_if.slave   bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  // Sweep counter is one bit wider than the address so the terminal value
  // DEPTH-1 never aliases with a wrapped counter.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   clrAddr_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [DATA_W-1:0] oldWord;
  logic [DATA_W-1:0] mergedWord;
  logic [DATA_W-1:0] rdWord_d;

  logic              stageValid;
  logic [DATA_W-1:0] stageData;
  logic              rvalid_q;
  logic [DATA_W-1:0] dout_q;

  assign accept = bus.req && (state_q == READY);

  // Build the word a write would leave behind: enabled bytes come from din,
  // the rest from the current array contents. rdWord_d is what the access
  // reports back, chosen by the read-during-write mode.
  always_comb begin
    oldWord    = mem[bus.addr];
    mergedWord = oldWord;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.we[i]) begin
        mergedWord[8*i +: 8] = bus.din[8*i +: 8];
      end
    end
    rdWord_d = (RDW_MODE != 0) ? mergedWord : oldWord;
  end

  // Clear sequencer. CLEAR walks clrAddr_q from 0 to DEPTH-1 one word per
  // edge; a clr request in either state restarts the walk at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clrAddr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (bus.clr) begin
            clrAddr_q <= '0;
          end else if (clrAddr_q == LAST_ADDR) begin
            state_q   <= READY;
            busy_q    <= 1'b0;
            clrAddr_q <= '0;
          end else begin
            clrAddr_q <= clrAddr_q + (ADDR_W+1)'(1);
          end
        end
        READY: begin
          if (bus.clr) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clrAddr_q <= '0;
          end
        end
        default: begin
          state_q   <= CLEAR;
          busy_q    <= 1'b1;
          clrAddr_q <= '0;
        end
      endcase
    end
  end

  // Storage array, deliberately without reset. While reset_n is low the
  // sequencer sits at address 0 in CLEAR, so the only effect is rewriting
  // word 0 with CLR_VAL, which the sweep does first anyway.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clrAddr_q[ADDR_W-1:0]] <= CLR_VAL;
    end else if (accept && (|bus.we)) begin
      mem[bus.addr] <= mergedWord;
    end
  end

  // The array is always sampled on the accept edge; the two-cycle variant
  // only adds a register between that sample and the output stage.
  generate
    if (RD_LAT == 2) begin : gLat2
      logic              pipeValid_q;
      logic [DATA_W-1:0] pipeData_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipeValid_q <= 1'b0;
          pipeData_q  <= '0;
        end else begin
          pipeValid_q <= accept;
          if (accept) begin
            pipeData_q <= rdWord_d;
          end
        end
      end

      assign stageValid = pipeValid_q;
      assign stageData  = pipeData_q;
    end else begin : gLat1
      assign stageValid = accept;
      assign stageData  = rdWord_d;
    end
  endgenerate

  // Output stage: dout only loads on a valid access so it holds between
  // rvalid pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      rvalid_q <= stageValid;
      if (stageValid) begin
        dout_q <= stageData;
      end
    end
  end

  assign bus.dout   = dout_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy_q;
  assign bus.rdy    = (state_q == READY);

endmodule
